rv_pipe_ctrl_md: RTL and testbench

//  Next-gen pipelined RV32 control unit: decodes opD/funct3D/funct7D, carries control through E/M/W.

---
 rtl/rv_pipe_ctrl_md.sv | 310 +++++++++++++++++++++++++++++++
 tb/tb_rv_pipe_ctrl_md.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_pipe_ctrl_md.sv
// rv_pipe_ctrl_md: pipelined RV32 control unit with E-stage MUL/DIV sequencing.
// Decodes the D-stage opcode fields, carries controls through E/M/W, and
// raises md_busyE while a multi-cycle multiply/divide occupies E.
// Optional feature macro: RV_MEXT_EN enables decode of the M extension and the
// multiply/divide sequencer; without it those encodings decode as illegal.
module rv_pipe_ctrl_md #(
   parameter int MUL_LAT = 3,
   parameter int DIV_LAT = 34
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] opD,
   input  logic [2:0] funct3D,
   input  logic [6:0] funct7D,
   output logic [2:0] ImmSrcD,
   output logic       ins_vldD,
   input  logic       FlushE,
   input  logic       StallE,
   input  logic       StallM,
   input  logic       takenE,
   output logic       PCSrcE,
   output logic       JumpE,
   output logic       BranchE,
   output logic [1:0] br_typeE,
   output logic       unsignE,
   output logic [4:0] ALUControlE,
   output logic [1:0] ALUSrcAE,
   output logic       ALUSrcBE,
   output logic       ResultSrcEb0,
   output logic       md_startE,
   output logic       md_busyE,
   output logic       RegWriteM,
   output logic [1:0] MemReadWriteM,
   output logic [1:0] data_typeM,
   output logic       unsignM,
   output logic       RegWriteW,
   output logic [1:0] ResultSrcW,
   output logic       illegalW
);

`ifdef RV_MEXT_EN
   localparam bit MEXT_ON = 1'b1;
`else
   localparam bit MEXT_ON = 1'b0;
`endif

   localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
   localparam int CNT_W   = $clog2(MAX_LAT) + 1;
   localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
   localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   localparam logic [4:0] ALU_ADD  = 5'b00000;
   localparam logic [4:0] ALU_SUB  = 5'b00001;
   localparam logic [4:0] ALU_AND  = 5'b00010;
   localparam logic [4:0] ALU_OR   = 5'b00011;
   localparam logic [4:0] ALU_XOR  = 5'b00100;
   localparam logic [4:0] ALU_SLT  = 5'b00101;
   localparam logic [4:0] ALU_SLL  = 5'b00110;
   localparam logic [4:0] ALU_SLTU = 5'b00111;
   localparam logic [4:0] ALU_SRL  = 5'b01000;
   localparam logic [4:0] ALU_SRA  = 5'b01001;

   typedef struct packed {
      logic       reg_write;
      logic [1:0] result_src;
      logic [1:0] mem_rw;
      logic [1:0] data_type;
      logic       unsign;
      logic       jump;
      logic       branch;
      logic [1:0] br_type;
      logic [4:0] alu_ctrl;
      logic [1:0] alu_src_a;
      logic       alu_src_b;
      logic       illegal;
   } ctrl_e_t;

   typedef struct packed {
      logic       reg_write;
      logic [1:0] result_src;
      logic [1:0] mem_rw;
      logic [1:0] data_type;
      logic       unsign;
      logic       illegal;
   } ctrl_m_t;

   typedef struct packed {
      logic       reg_write;
      logic [1:0] result_src;
      logic       illegal;
   } ctrl_w_t;

   ctrl_e_t          dec;
   ctrl_e_t          ctrl_e;
   ctrl_m_t          m_next;
   ctrl_m_t          ctrl_m;
   ctrl_w_t          ctrl_w;
   logic [2:0]       imm_src;
   logic             valid;
   logic             load_e;
   logic             md_load;
   logic [CNT_W-1:0] md_lat;
   logic [CNT_W-1:0] cnt;
   logic             done;
   logic             start;

   function automatic logic [4:0] alu_base(input logic [2:0] f3, input logic alt);
      logic [4:0] op;
      case (f3)
         3'b000:  op = alt ? ALU_SUB : ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLTU;
         3'b100:  op = ALU_XOR;
         3'b101:  op = alt ? ALU_SRA : ALU_SRL;
         3'b110:  op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

   // Decode the D-stage fields; anything unimplemented collapses to all-zero controls.
   always_comb begin
      dec     = '0;
      imm_src = 3'd0;
      valid   = 1'b1;
      case (opD)
         7'b0000011: begin
            dec.reg_write  = 1'b1;
            dec.result_src = 2'b01;
            dec.mem_rw     = 2'b10;
            dec.alu_src_b  = 1'b1;
            case (funct3D)
               3'b000:  dec.data_type = 2'b10;
               3'b001:  dec.data_type = 2'b01;
               3'b010:  dec.data_type = 2'b00;
               3'b100:  begin dec.data_type = 2'b10; dec.unsign = 1'b1; end
               3'b101:  begin dec.data_type = 2'b01; dec.unsign = 1'b1; end
               default: valid = 1'b0;
            endcase
         end
         7'b0100011: begin
            imm_src       = 3'd1;
            dec.mem_rw    = 2'b01;
            dec.alu_src_b = 1'b1;
            case (funct3D)
               3'b000:  dec.data_type = 2'b10;
               3'b001:  dec.data_type = 2'b01;
               3'b010:  dec.data_type = 2'b00;
               default: valid = 1'b0;
            endcase
         end
         7'b0110011: begin
            dec.reg_write = 1'b1;
            if (funct7D == 7'b0000000) begin
               dec.alu_ctrl = alu_base(funct3D, 1'b0);
               dec.unsign   = (funct3D == 3'b011);
            end else if (funct7D == 7'b0100000 && (funct3D == 3'b000 || funct3D == 3'b101)) begin
               dec.alu_ctrl = alu_base(funct3D, funct7D[5] & opD[5]);
`ifdef RV_MEXT_EN
            end else if (funct7D == 7'b0000001) begin
               dec.alu_ctrl = {2'b10, funct3D};
`endif
            end else begin
               valid = 1'b0;
            end
         end
         7'b0010011: begin
            dec.reg_write = 1'b1;
            dec.alu_src_b = 1'b1;
            if (funct3D == 3'b001) begin
               dec.alu_ctrl = ALU_SLL;
               valid        = (funct7D == 7'b0000000);
            end else if (funct3D == 3'b101) begin
               dec.alu_ctrl = alu_base(funct3D, funct7D[5]);
               valid        = (funct7D == 7'b0000000) || (funct7D == 7'b0100000);
            end else begin
               dec.alu_ctrl = alu_base(funct3D, 1'b0);
               dec.unsign   = (funct3D == 3'b011);
            end
         end
         7'b1100011: begin
            imm_src      = 3'd2;
            dec.branch   = 1'b1;
            dec.alu_ctrl = ALU_SUB;
            case (funct3D)
               3'b000:  dec.br_type = 2'b00;
               3'b001:  dec.br_type = 2'b01;
               3'b100:  dec.br_type = 2'b10;
               3'b101:  dec.br_type = 2'b11;
               3'b110:  begin dec.br_type = 2'b10; dec.unsign = 1'b1; end
               3'b111:  begin dec.br_type = 2'b11; dec.unsign = 1'b1; end
               default: valid = 1'b0;
            endcase
         end
         7'b1101111: begin
            imm_src        = 3'd3;
            dec.reg_write  = 1'b1;
            dec.jump       = 1'b1;
            dec.result_src = 2'b10;
         end
         7'b1100111: begin
            dec.reg_write  = 1'b1;
            dec.jump       = 1'b1;
            dec.result_src = 2'b10;
            dec.alu_src_b  = 1'b1;
            valid          = (funct3D == 3'b000);
         end
         7'b0110111: begin
            imm_src       = 3'd4;
            dec.reg_write = 1'b1;
            dec.alu_src_a = 2'b01;
            dec.alu_src_b = 1'b1;
         end
         7'b0010111: begin
            imm_src       = 3'd4;
            dec.reg_write = 1'b1;
            dec.alu_src_a = 2'b11;
            dec.alu_src_b = 1'b1;
         end
         default: valid = 1'b0;
      endcase
      if (!valid) begin
         dec         = '0;
         imm_src     = 3'd0;
         dec.illegal = (opD != 7'b0000000);
      end
   end

   assign ImmSrcD  = imm_src;
   assign ins_vldD = valid;

   assign load_e  = reset && !FlushE && !StallE;
   assign md_load = load_e && dec.alu_ctrl[4] && MEXT_ON;
   assign md_lat  = funct3D[2] ? DIV_CNT : MUL_CNT;

   // E pipeline register: flush and reset insert a bubble, StallE holds.
   always_ff @(posedge clk) begin
      if (!reset || FlushE) ctrl_e <= '0;
      else if (!StallE)     ctrl_e <= dec;
   end

   // Multiply/divide occupancy counter; it keeps counting through StallE and only a fresh load restarts it.
   always_ff @(posedge clk) begin
      if (!reset || FlushE) begin
         cnt   <= '0;
         done  <= 1'b0;
         start <= 1'b0;
      end else begin
         start <= md_load;
         if (md_load) begin
            cnt  <= md_lat;
            done <= (md_lat == '0);
         end else if (load_e) begin
            cnt  <= '0;
            done <= 1'b0;
         end else if (cnt != '0) begin
            cnt <= cnt - CNT_ONE;
            if (cnt == CNT_ONE) done <= 1'b1;
         end
      end
   end

   assign md_startE    = start;
   assign md_busyE     = MEXT_ON && ctrl_e.alu_ctrl[4] && (cnt != '0) && !done;
   assign PCSrcE       = (ctrl_e.branch & takenE) | ctrl_e.jump;
   assign JumpE        = ctrl_e.jump;
   assign BranchE      = ctrl_e.branch;
   assign br_typeE     = ctrl_e.br_type;
   assign unsignE      = ctrl_e.unsign;
   assign ALUControlE  = ctrl_e.alu_ctrl;
   assign ALUSrcAE     = ctrl_e.alu_src_a;
   assign ALUSrcBE     = ctrl_e.alu_src_b;
   assign ResultSrcEb0 = ctrl_e.result_src[0];

   // While the multi-cycle op is still running, M receives a bubble instead of the E controls.
   always_comb begin
      m_next = '0;
      if (!md_busyE) begin
         m_next.reg_write  = ctrl_e.reg_write;
         m_next.result_src = ctrl_e.result_src;
         m_next.mem_rw     = ctrl_e.mem_rw;
         m_next.data_type  = ctrl_e.data_type;
         m_next.unsign     = ctrl_e.unsign;
         m_next.illegal    = ctrl_e.illegal;
      end
   end

   // M pipeline register, held by StallM.
   always_ff @(posedge clk) begin
      if (!reset)       ctrl_m <= '0;
      else if (!StallM) ctrl_m <= m_next;
   end

   // W pipeline register, advances every cycle.
   always_ff @(posedge clk) begin
      if (!reset) ctrl_w <= '0;
      else        ctrl_w <= '{reg_write: ctrl_m.reg_write, result_src: ctrl_m.result_src, illegal: ctrl_m.illegal};
   end

   assign RegWriteM     = ctrl_m.reg_write;
   assign MemReadWriteM = ctrl_m.mem_rw;
   assign data_typeM    = ctrl_m.data_type;
   assign unsignM       = ctrl_m.unsign;
   assign RegWriteW     = ctrl_w.reg_write;
   assign ResultSrcW    = ctrl_w.result_src;
   assign illegalW      = ctrl_w.illegal;

endmodule

// File: tb/tb_rv_pipe_ctrl_md.sv
// tb_rv_pipe_ctrl_md: directed bench for rv_pipe_ctrl_md.
// Builds with or without RV_MEXT_EN; the multiply/divide steps follow the macro.
module tb_rv_pipe_ctrl_md;

   logic       clk = 1'b0;
   logic       reset;
   logic [6:0] opD;
   logic [2:0] funct3D;
   logic [6:0] funct7D;
   logic [2:0] ImmSrcD;
   logic       ins_vldD;
   logic       FlushE, StallE, StallM, takenE;
   logic       PCSrcE, JumpE, BranchE;
   logic [1:0] br_typeE;
   logic       unsignE;
   logic [4:0] ALUControlE;
   logic [1:0] ALUSrcAE;
   logic       ALUSrcBE, ResultSrcEb0, md_startE, md_busyE;
   logic       RegWriteM;
   logic [1:0] MemReadWriteM, data_typeM;
   logic       unsignM, RegWriteW;
   logic [1:0] ResultSrcW;
   logic       illegalW;

   int n_checks = 0;
   int n_fail   = 0;
   int busy_cycles;
   int m_writes;
   int w_writes;

   rv_pipe_ctrl_md #(.MUL_LAT(3), .DIV_LAT(34)) dut (
      .clk(clk), .reset(reset), .opD(opD), .funct3D(funct3D), .funct7D(funct7D),
      .ImmSrcD(ImmSrcD), .ins_vldD(ins_vldD), .FlushE(FlushE), .StallE(StallE),
      .StallM(StallM), .takenE(takenE), .PCSrcE(PCSrcE), .JumpE(JumpE),
      .BranchE(BranchE), .br_typeE(br_typeE), .unsignE(unsignE),
      .ALUControlE(ALUControlE), .ALUSrcAE(ALUSrcAE), .ALUSrcBE(ALUSrcBE),
      .ResultSrcEb0(ResultSrcEb0), .md_startE(md_startE), .md_busyE(md_busyE),
      .RegWriteM(RegWriteM), .MemReadWriteM(MemReadWriteM), .data_typeM(data_typeM),
      .unsignM(unsignM), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW),
      .illegalW(illegalW)
   );

   // Free-running clock, 10 time units per cycle.
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
      opD     = op;
      funct3D = f3;
      funct7D = f7;
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_checks++;
      assert (observed === expected)
      else begin
         n_fail++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Hard time limit so a stuck design still ends the run.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed stimulus, one step after another.
   initial begin
      reset = 1'b0; FlushE = 1'b0; StallE = 1'b0; StallM = 1'b0; takenE = 1'b0;
      applyStimulus(7'b0110011, 3'b000, 7'b0000000);
      tick(); tick();
      checkOutput("rst_ALUControlE", ALUControlE, 0);
      checkOutput("rst_RegWriteM", RegWriteM, 0);
      checkOutput("rst_RegWriteW", RegWriteW, 0);
      checkOutput("rst_illegalW", illegalW, 0);
      checkOutput("rst_md_busyE", md_busyE, 0);
      checkOutput("rst_md_startE", md_startE, 0);

      // add x1,x2,x3 through the pipe
      reset = 1'b1;
      applyStimulus(7'b0110011, 3'b000, 7'b0000000);
      checkOutput("add_ins_vldD", ins_vldD, 1);
      tick();
      checkOutput("add_ALUControlE", ALUControlE, 5'b00000);
      checkOutput("add_ALUSrcBE", ALUSrcBE, 0);
      applyStimulus(7'b0000000, 3'b000, 7'b0000000);
      tick();
      checkOutput("add_RegWriteM", RegWriteM, 1);
      tick();
      checkOutput("add_RegWriteW", RegWriteW, 1);
      checkOutput("add_ResultSrcW", ResultSrcW, 2'b00);

      // beq taken, then condition dropped
      applyStimulus(7'b1100011, 3'b000, 7'b0000000);
      checkOutput("beq_ImmSrcD", ImmSrcD, 3'd2);
      takenE = 1'b1;
      tick();
      checkOutput("beq_PCSrcE", PCSrcE, 1);
      checkOutput("beq_br_typeE", br_typeE, 2'b00);
      checkOutput("beq_BranchE", BranchE, 1);
      takenE = 1'b0;
      #1;
      checkOutput("beq_nottaken_PCSrcE", PCSrcE, 0);

      // bgeu
      applyStimulus(7'b1100011, 3'b111, 7'b0000000);
      tick();
      checkOutput("bgeu_unsignE", unsignE, 1);
      checkOutput("bgeu_br_typeE", br_typeE, 2'b11);

      // sltu
      applyStimulus(7'b0110011, 3'b011, 7'b0000000);
      tick();
      checkOutput("sltu_unsignE", unsignE, 1);
      checkOutput("sltu_ALUControlE", ALUControlE, 5'b00111);

      // addi whose immediate top bits look like funct7=0100000 stays an add
      applyStimulus(7'b0010011, 3'b000, 7'b0100000);
      tick();
      checkOutput("addi_ALUControlE", ALUControlE, 5'b00000);
      checkOutput("addi_ALUSrcBE", ALUSrcBE, 1);

      // lbu, sw, lui back to back
      applyStimulus(7'b0000011, 3'b100, 7'b0000000);
      tick();
      checkOutput("lbu_ResultSrcEb0", ResultSrcEb0, 1);
      applyStimulus(7'b0100011, 3'b010, 7'b0000000);
      checkOutput("sw_ImmSrcD", ImmSrcD, 3'd1);
      tick();
      checkOutput("lbu_MemReadWriteM", MemReadWriteM, 2'b10);
      checkOutput("lbu_data_typeM", data_typeM, 2'b10);
      checkOutput("lbu_unsignM", unsignM, 1);
      applyStimulus(7'b0110111, 3'b000, 7'b0000000);
      checkOutput("lui_ImmSrcD", ImmSrcD, 3'd4);
      tick();
      checkOutput("sw_MemReadWriteM", MemReadWriteM, 2'b01);
      checkOutput("sw_data_typeM", data_typeM, 2'b00);
      checkOutput("lui_ALUSrcAE", ALUSrcAE, 2'b01);
      checkOutput("lbu_ResultSrcW", ResultSrcW, 2'b01);
      applyStimulus(7'b0010111, 3'b000, 7'b0000000);
      tick();
      checkOutput("auipc_ALUSrcAE", ALUSrcAE, 2'b11);

      // jal writes PC+4
      applyStimulus(7'b1101111, 3'b000, 7'b0000000);
      checkOutput("jal_ImmSrcD", ImmSrcD, 3'd3);
      tick();
      checkOutput("jal_JumpE", JumpE, 1);
      checkOutput("jal_PCSrcE", PCSrcE, 1);
      applyStimulus(7'b0000000, 3'b000, 7'b0000000);
      tick(); tick();
      checkOutput("jal_ResultSrcW", ResultSrcW, 2'b10);

      // undefined opcode
      applyStimulus(7'b1111111, 3'b000, 7'b0000000);
      checkOutput("ill_ins_vldD", ins_vldD, 0);
      checkOutput("ill_ImmSrcD", ImmSrcD, 0);
      tick();
      checkOutput("ill_ALUControlE", ALUControlE, 0);
      checkOutput("ill_JumpE", JumpE, 0);
      applyStimulus(7'b0000000, 3'b000, 7'b0000000);
      tick(); tick();
      checkOutput("ill_illegalW", illegalW, 1);
      checkOutput("ill_RegWriteW", RegWriteW, 0);

      // all-zero opcode is not illegal
      checkOutput("zero_ins_vldD", ins_vldD, 0);
      tick(); tick(); tick();
      checkOutput("zero_illegalW", illegalW, 0);

      // FlushE drops the incoming jal
      applyStimulus(7'b1101111, 3'b000, 7'b0000000);
      FlushE = 1'b1;
      tick();
      checkOutput("flush_JumpE", JumpE, 0);
      FlushE = 1'b0;
      applyStimulus(7'b0000000, 3'b000, 7'b0000000);
      tick();
      checkOutput("flush_RegWriteM", RegWriteM, 0);

      // StallE holds E
      applyStimulus(7'b1101111, 3'b000, 7'b0000000);
      tick();
      StallE = 1'b1;
      applyStimulus(7'b0000000, 3'b000, 7'b0000000);
      tick();
      checkOutput("stallE_JumpE_held", JumpE, 1);
      StallE = 1'b0;
      tick();
      checkOutput("stallE_JumpE_released", JumpE, 0);
      tick(); tick();

      // StallM holds M
      applyStimulus(7'b0110011, 3'b000, 7'b0000000);
      tick();
      applyStimulus(7'b0000000, 3'b000, 7'b0000000);
      tick();
      StallM = 1'b1;
      tick();
      checkOutput("stallM_RegWriteM_held", RegWriteM, 1);
      StallM = 1'b0;
      tick();
      checkOutput("stallM_RegWriteM_released", RegWriteM, 0);

`ifdef RV_MEXT_EN
      // div: start pulse, 33 busy cycles, bubbles into M, then one write
      applyStimulus(7'b0110011, 3'b100, 7'b0000001);
      checkOutput("div_ins_vldD", ins_vldD, 1);
      tick();
      checkOutput("div_md_startE", md_startE, 1);
      checkOutput("div_md_busyE", md_busyE, 1);
      checkOutput("div_ALUControlE", ALUControlE, 5'b10100);
      applyStimulus(7'b0000000, 3'b000, 7'b0000000);
      busy_cycles = 1;
      m_writes    = 0;
      for (int i = 0; i < 60; i++) begin
         StallE = md_busyE;
         if (!md_busyE) break;
         tick();
         if (md_busyE) busy_cycles++;
         if (RegWriteM) m_writes++;
         if (i == 0) checkOutput("div_start_pulse", md_startE, 0);
      end
      StallE = 1'b0;
      checkOutput("div_busy_cycles", busy_cycles, 33);
      checkOutput("div_bubble_writes", m_writes, 0);
      tick();
      checkOutput("div_RegWriteM", RegWriteM, 1);
      tick(); tick(); tick();

      // div flushed at busy cycle 5
      applyStimulus(7'b0110011, 3'b100, 7'b0000001);
      tick();
      applyStimulus(7'b0000000, 3'b000, 7'b0000000);
      StallE = 1'b1;
      tick(); tick(); tick(); tick();
      checkOutput("divflush_busy_c5", md_busyE, 1);
      FlushE = 1'b1;
      tick();
      FlushE = 1'b0;
      StallE = 1'b0;
      checkOutput("divflush_md_busyE", md_busyE, 0);
      checkOutput("divflush_ALUControlE", ALUControlE, 0);
      w_writes = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (RegWriteM || RegWriteW) w_writes++;
      end
      checkOutput("divflush_writes", w_writes, 0);

      // mul held in E after completion
      applyStimulus(7'b0110011, 3'b000, 7'b0000001);
      tick();
      checkOutput("mul_md_startE", md_startE, 1);
      applyStimulus(7'b0000000, 3'b000, 7'b0000000);
      StallE = 1'b1;
      tick(); tick();
      checkOutput("mul_done_busy", md_busyE, 0);
      StallM = 1'b1;
      busy_cycles = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (md_busyE || md_startE) busy_cycles++;
      end
      checkOutput("mul_stall_restart", busy_cycles, 0);
      StallE = 1'b0;
      StallM = 1'b0;
      w_writes = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (RegWriteW) w_writes++;
      end
      checkOutput("mul_writebacks", w_writes, 1);
`else
      // without the M extension a mul is illegal
      applyStimulus(7'b0110011, 3'b000, 7'b0000001);
      checkOutput("nomext_ins_vldD", ins_vldD, 0);
      tick();
      checkOutput("nomext_md_startE", md_startE, 0);
      checkOutput("nomext_md_busyE", md_busyE, 0);
      checkOutput("nomext_ALUControlE", ALUControlE, 0);
      applyStimulus(7'b0000000, 3'b000, 7'b0000000);
      tick(); tick();
      checkOutput("nomext_illegalW", illegalW, 1);
      checkOutput("nomext_RegWriteW", RegWriteW, 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
